pht_update_scheduler: RTL and testbench
=======================================

// Module: pht_update_scheduler
// PURPOSE
// - Sequences writes into the 2-bit pattern history table (PHT) from resolved branches.
// - Queues branch outcomes from EX/MEM in a small FIFO and does read-modify-write with saturating-counter math.
// - Shares the single PHT read port between fetch-stage lookups (priority) and its own update reads.
// - Sits between the branch-resolution stage, the fetch predictor and the PHT storage array.
// PARAMETERS
// - IDX_W       4  PHT index width (2**IDX_W entries)
// - DEPTH       4  update FIFO depth, power of 2, >=2
// - STARVE_LIM  8  consecutive lookup-won cycles with a pending update before the scheduler steals the port
// PORTS
// - clk          in   1      clock, all state on posedge
// - rst_n        in   1      asynchronous active-low reset
// - upd_valid    in   1      resolved conditional branch outcome offered
// - upd_ready    out  1      FIFO can accept (= !full)
// - upd_idx      in   IDX_W  PHT index of resolved branch
// - upd_taken    in   1      1 = branch taken
// - stall        in   1      pipeline stall; blocks PHT write commit
// - lk_valid     in   1      fetch lookup request
// - lk_idx       in   IDX_W  fetch lookup index
// - lk_grant     out  1      lookup owns read port this cycle; lk_ctr valid
// - lk_ctr       out  2      counter returned to fetch (bit1 = predict taken)
// - pht_rd_idx   out  IDX_W  PHT combinational read index
// - pht_rd_data  in   2      PHT read data (same cycle)
// - pht_we       out  1      PHT write enable
// - pht_wr_idx   out  IDX_W  PHT write index
// - pht_wr_data  out  2      PHT write data
// - fifo_count   out  log2(DEPTH)+1  queued updates
// BEHAVIOUR
// - Reset (async, rst_n=0): FIFO empty, pointers 0, state IDLE, starve_cnt 0, ctr_q 0.
// - Outputs during reset: upd_ready=1, pht_we=0, lk_grant=0, fifo_count=0.
// - Reset mid-operation discards queued and in-flight updates; no PHT write occurs.
// - Push: upd_valid && upd_ready -> store {idx,taken} at wr_ptr; pointers wrap mod DEPTH.
// - Full: upd_ready=0 even if a pop happens the same cycle; no push-through when full.
// - Port arbitration (comb):
//   - steal = state==IDLE && !empty && starve_cnt==STARVE_LIM.
//   - lk_grant = lk_valid && !steal.
//   - pht_rd_idx = lk_grant ? lk_idx : head.idx.
//   - lk_ctr = pht_rd_data.
// - starve_cnt: +1 (saturating at STARVE_LIM) when IDLE && !empty && lk_grant; otherwise 0.
// - FSM:
//   - IDLE: if !empty && !lk_grant -> ctr_q<=pht_rd_data, tk_q<=head.taken, ix_q<=head.idx; go WRITE.
//   - WRITE: pht_we=!stall, pht_wr_idx=ix_q, pht_wr_data=sat(ctr_q,tk_q).
//     - If !stall: pop head, go IDLE.
//     - Else hold WRITE with all regs unchanged.
// - sat(): taken -> ctr==3?3:ctr+1; not-taken -> ctr==0?0:ctr-1. No wrap, 2-bit only.
// - Throughput: 1 update / 2 cycles min.
// - The next IDLE read sees the prior write (PHT writes on posedge), so same-index back-to-back updates are exact.
// - In WRITE the port is free: lk_grant=lk_valid, pht_rd_idx=lk_idx.
// - pht_we is never asserted in IDLE or while stall=1.
// CONFIGURATION
// - PHT_FWD_EN defined:
//   - In WRITE with pht_we=1 and lk_grant && lk_idx==ix_q, lk_ctr=pht_wr_data (forward new value).
// - PHT_FWD_EN undefined:
//   - lk_ctr is always pht_rd_data (stale value that cycle). All else identical.
// TESTING
// - Reset, PHT[5]=2'b11, push idx5 not-taken, lk_valid=0:
//   - Cycle +1 IDLE reads 3.
//   - Cycle +2 pht_we=1, idx5, data 2'b10, fifo_count back to 0.
// - Saturation:
//   - PHT[2]=3, push taken x3 -> three writes of 2'b11.
//   - PHT[2]=0, push not-taken -> write 2'b00.
// - Fill: push 4 updates with lk_valid=1 held (STARVE_LIM=8):
//   - upd_ready=0 at count 4; 5th offer not accepted.
//   - After 8 grant cycles, lk_grant=0 one cycle and the update reads.
// - Stall: in WRITE assert stall 3 cycles -> pht_we=0, state held; on release exactly one write, then pop.
// - Back-to-back same index: PHT[9]=1, push taken, taken -> writes 2 then 3 (not 2,2).
// - PHT_FWD_EN: WRITE idx7 new=2 old=1, lk_idx=7 same cycle -> lk_ctr=2 with macro, 1 without.
// - Async reset asserted while in WRITE with 3 queued -> pht_we drops immediately, fifo_count=0, no later writes.

Source files
------------

// File: rtl/pht_update_scheduler.sv
// Queues resolved-branch outcomes and read-modify-writes the 2-bit PHT through a port shared with fetch.
// Build option: define PHT_FWD_EN to forward the value being written to a same-index lookup.
module pht_update_scheduler #(
  parameter int IDX_W      = 4,
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     upd_valid,
  output logic                     upd_ready,
  input  logic [IDX_W-1:0]         upd_idx,
  input  logic                     upd_taken,
  input  logic                     stall,
  input  logic                     lk_valid,
  input  logic [IDX_W-1:0]         lk_idx,
  output logic                     lk_grant,
  output logic [1:0]               lk_ctr,
  output logic [IDX_W-1:0]         pht_rd_idx,
  input  logic [1:0]               pht_rd_data,
  output logic                     pht_we,
  output logic [IDX_W-1:0]         pht_wr_idx,
  output logic [1:0]               pht_wr_data,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } upd_t;

  typedef enum logic {IDLE, WRITE} state_t;

  function automatic logic [1:0] sat2(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? c : c + 2'd1;
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  upd_t             fifo_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  state_t           state_q, state_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic [1:0]       ctr_q, ctr_d;
  logic             tk_q, tk_d;
  logic [IDX_W-1:0] ix_q, ix_d;

  logic empty, full, push, pop, steal;
  logic [1:0] new_ctr;
  upd_t head;

  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == CW'(DEPTH));
  assign head       = fifo_q[rd_ptr_q];
  assign upd_ready  = !full;
  assign push       = upd_valid && !full;
  assign fifo_count = cnt_q;

  // Fetch wins the read port unless a pending update has been starved long enough.
  assign steal      = (state_q == IDLE) && !empty && (starve_q == SW'(STARVE_LIM));
  assign lk_grant   = rst_n && lk_valid && !steal;
  assign pht_rd_idx = lk_grant ? lk_idx : head.idx;

  assign new_ctr     = sat2(ctr_q, tk_q);
  assign pht_wr_idx  = ix_q;
  assign pht_wr_data = new_ctr;

`ifdef PHT_FWD_EN
  assign lk_ctr = (pht_we && lk_grant && (lk_idx == ix_q)) ? new_ctr : pht_rd_data;
`else
  assign lk_ctr = pht_rd_data;
`endif

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{idx: upd_idx, taken: upd_taken};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      starve_q <= '0;
      ctr_q    <= '0;
      tk_q     <= 1'b0;
      ix_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q    <= cnt_q + CW'(push) - CW'(pop);
      state_q  <= state_d;
      starve_q <= starve_d;
      ctr_q    <= ctr_d;
      tk_q     <= tk_d;
      ix_q     <= ix_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = '0;
    ctr_d    = ctr_q;
    tk_d     = tk_q;
    ix_d     = ix_q;
    pht_we   = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && lk_grant) begin
          starve_d = (starve_q == SW'(STARVE_LIM)) ? starve_q : starve_q + SW'(1);
        end else if (!empty) begin
          ctr_d   = pht_rd_data;
          tk_d    = head.taken;
          ix_d    = head.idx;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // The entry stays at the head until its write commits, so a stall simply holds everything.
        pht_we = !stall;
        if (!stall) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_pht_update_scheduler.sv
// Bench for pht_update_scheduler: queue-based reference model checked every cycle, plus directed literal cases.
module tb_pht_update_scheduler;
  localparam int IDX_W = 4, DEPTH = 4, LIM = 8;

  logic clk, rst_n, upd_valid, upd_ready, upd_taken, stall, lk_valid, lk_grant, pht_we;
  logic [IDX_W-1:0] upd_idx, lk_idx, pht_rd_idx, pht_wr_idx;
  logic [1:0] lk_ctr, pht_rd_data, pht_wr_data;
  logic [2:0] fifo_count;

  pht_update_scheduler #(.IDX_W(IDX_W), .DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_idx(upd_idx), .upd_taken(upd_taken), .stall(stall), .lk_valid(lk_valid),
    .lk_idx(lk_idx), .lk_grant(lk_grant), .lk_ctr(lk_ctr), .pht_rd_idx(pht_rd_idx),
    .pht_rd_data(pht_rd_data), .pht_we(pht_we), .pht_wr_idx(pht_wr_idx),
    .pht_wr_data(pht_wr_data), .fifo_count(fifo_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PHT storage array
  logic [1:0] mem  [16] = '{default: 2'b00};
  logic [1:0] refm [16] = '{default: 2'b00};
  logic [1:0] snap [16];
  logic       pre_en;
  logic [3:0] pre_idx;
  logic [1:0] pre_val;
  assign pht_rd_data = mem[pht_rd_idx];
  always @(posedge clk) begin
    if (pht_we) mem[pht_wr_idx] <= pht_wr_data;
    if (pre_en) mem[pre_idx] <= pre_val;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
    int v;
    v = int'(c);
    if (t) v = (v == 3) ? 3 : v + 1;
    else   v = (v == 0) ? 0 : v - 1;
    return 2'(v);
  endfunction

  // Reference model: outstanding updates in arrival order, one of which may be in flight.
  typedef struct packed { logic [3:0] idx; logic tk; } upd_t;
  upd_t       mq [$];
  bit         m_busy;
  logic [3:0] m_widx;
  logic [1:0] m_wdata;
  int         m_starve;
  logic [5:0] wlog [$];

  always @(negedge clk) begin : model
    int n;
    bit steal, eg, ewe;
    logic [1:0] ectr;
    if (!rst_n) begin
      chk("rst_ready", upd_ready, 1);
      chk("rst_we", pht_we, 0);
      chk("rst_grant", lk_grant, 0);
      chk("rst_count", fifo_count, 0);
      mq.delete();
      m_busy = 0;
      m_starve = 0;
      for (int i = 0; i < 16; i++) refm[i] = mem[i];
    end else begin
      n     = mq.size();
      steal = !m_busy && n > 0 && m_starve == LIM;
      eg    = lk_valid && !steal;
      ewe   = m_busy && !stall;
      chk("ready", upd_ready, n < DEPTH);
      chk("count", fifo_count, n);
      chk("grant", lk_grant, eg);
      chk("we", pht_we, ewe);
      if (ewe) begin
        chk("wr_idx", pht_wr_idx, m_widx);
        chk("wr_data", pht_wr_data, m_wdata);
      end
      if (eg) begin
        chk("rd_idx_lk", pht_rd_idx, lk_idx);
        ectr = mem[lk_idx];
`ifdef PHT_FWD_EN
        if (ewe && lk_idx == m_widx) ectr = m_wdata;
`endif
        chk("lk_ctr", lk_ctr, ectr);
      end else if (!m_busy && n > 0) begin
        chk("rd_idx_upd", pht_rd_idx, mq[0].idx);
      end
      if (pht_we) wlog.push_back({pht_wr_idx, pht_wr_data});
      // advance to the state after the coming edge
      if (!m_busy && n > 0 && eg) m_starve = (m_starve >= LIM) ? LIM : m_starve + 1;
      else m_starve = 0;
      if (m_busy) begin
        if (!stall) begin
          void'(mq.pop_front());
          m_busy = 0;
        end
      end else if (n > 0 && !eg) begin
        m_busy  = 1;
        m_widx  = mq[0].idx;
        m_wdata = sat(mem[mq[0].idx], mq[0].tk);
      end
      if (upd_valid && n < DEPTH) begin
        mq.push_back('{idx: upd_idx, tk: upd_taken});
        refm[upd_idx] = sat(refm[upd_idx], upd_taken);
      end
      if (pre_en) refm[pre_idx] = pre_val;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] i, input logic [1:0] v);
    pre_en = 1; pre_idx = i; pre_val = v;
    step();
    pre_en = 0;
  endtask

  task automatic push(input logic [3:0] i, input logic t);
    upd_valid = 1; upd_idx = i; upd_taken = t;
    step();
    upd_valid = 0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (fifo_count == 0 && !pht_we) done = 1;
    end
    chk("drain_timeout", done, 1);
    step();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int g;
    bit seen;
    rst_n = 0; upd_valid = 0; upd_idx = 0; upd_taken = 0; stall = 0;
    lk_valid = 1; lk_idx = 4'h3; pre_en = 0; pre_idx = 0; pre_val = 0;
    chk("sat_3t", sat(2'd3, 1'b1), 3);
    chk("sat_0n", sat(2'd0, 1'b0), 0);
    chk("sat_1t", sat(2'd1, 1'b1), 2);
    chk("sat_2n", sat(2'd2, 1'b0), 1);
    repeat (2) step();
    rst_n = 1; lk_valid = 0;
    step();

    // single not-taken update on a strongly-taken entry
    preload(5, 3);
    wlog.delete();
    push(5, 0);
    @(negedge clk);
    chk("a_we_c1", pht_we, 0);
    chk("a_rdidx_c1", pht_rd_idx, 5);
    step();
    @(negedge clk);
    chk("a_we_c2", pht_we, 1);
    chk("a_widx_c2", pht_wr_idx, 5);
    chk("a_wdata_c2", pht_wr_data, 2);
    step();
    chk("a_count_after", fifo_count, 0);

    // saturation at both ends
    preload(2, 3);
    wlog.delete();
    push(2, 1); push(2, 1); push(2, 1);
    drain();
    chk("sat_hi_n", wlog.size(), 3);
    for (int i = 0; i < wlog.size(); i++) chk("sat_hi_w", wlog[i], {4'd2, 2'd3});
    preload(2, 0);
    wlog.delete();
    push(2, 0);
    drain();
    chk("sat_lo_n", wlog.size(), 1);
    if (wlog.size() > 0) chk("sat_lo_w", wlog[0], {4'd2, 2'd0});

    // fill under continuous lookups, then starvation steal
    wlog.delete();
    lk_valid = 1; lk_idx = 4'hE;
    push(1, 1); push(3, 0); push(6, 1); push(8, 0);
    chk("fill_ready", upd_ready, 0);
    chk("fill_count4", fifo_count, 4);
    upd_valid = 1; upd_idx = 4'hF; upd_taken = 1;
    step();
    upd_valid = 0;
    chk("fill_no5th", fifo_count, 4);
    g = 4; seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (lk_grant) g++;
      else begin
        seen = 1;
        chk("steal_rdidx", pht_rd_idx, 1);
      end
    end
    chk("starve_grants", g, 8);
    step();
    lk_valid = 0;
    drain();
    chk("fill_writes", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("fill_o0", wlog[0][5:2], 1);
      chk("fill_o1", wlog[1][5:2], 3);
      chk("fill_o2", wlog[2][5:2], 6);
      chk("fill_o3", wlog[3][5:2], 8);
    end

    // stall holds the write
    preload(3, 1);
    wlog.delete();
    push(3, 1);
    stall = 1;
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_we", pht_we, 0);
      chk("stall_cnt", fifo_count, 1);
      step();
    end
    stall = 0;
    @(negedge clk);
    chk("unstall_we", pht_we, 1);
    chk("unstall_data", pht_wr_data, 2);
    step();
    chk("unstall_cnt", fifo_count, 0);
    drain();
    chk("stall_nwr", wlog.size(), 1);

    // back-to-back same index
    preload(9, 1);
    wlog.delete();
    push(9, 1); push(9, 1);
    drain();
    chk("b2b_n", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("b2b_w0", wlog[0], {4'd9, 2'd2});
      chk("b2b_w1", wlog[1], {4'd9, 2'd3});
    end

    // lookup hitting the entry being written
    preload(7, 1);
    push(7, 1);
    step();
    lk_valid = 1; lk_idx = 7;
    @(negedge clk);
    chk("fwd_we", pht_we, 1);
    chk("fwd_grant", lk_grant, 1);
`ifdef PHT_FWD_EN
    chk("fwd_ctr", lk_ctr, 2);
`else
    chk("fwd_ctr", lk_ctr, 1);
`endif
    step();
    lk_valid = 0;
    drain();

    // async reset while writing with three queued
    stall = 1;
    wlog.delete();
    push(10, 1); push(11, 0); push(12, 1);
    stall = 0;
    #1;
    chk("prerst_we", pht_we, 1);
    chk("prerst_cnt", fifo_count, 3);
    for (int i = 0; i < 16; i++) snap[i] = mem[i];
    rst_n = 0;
    #1;
    chk("rst_we_now", pht_we, 0);
    chk("rst_cnt_now", fifo_count, 0);
    step(); step();
    rst_n = 1;
    repeat (10) step();
    chk("rst_nowr", wlog.size(), 0);
    for (int i = 0; i < 16; i++) chk("rst_mem", mem[i], snap[i]);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      upd_valid = 1'($urandom_range(1));
      upd_idx   = 4'($urandom_range(15));
      upd_taken = 1'($urandom_range(1));
      lk_valid  = ($urandom_range(7) < 5);
      lk_idx    = 4'($urandom_range(15));
      stall     = ($urandom_range(4) == 0);
      step();
    end
    upd_valid = 0; lk_valid = 0; stall = 0;
    drain();
    for (int i = 0; i < 16; i++) chk("final_pht", mem[i], refm[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
